// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } owner_t;

    function automatic int blk_width(input int data_width, input int block_size);
        return data_width * (2 ** block_size);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing datamemory between I-cache refill and D-cache
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 1,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        ic_req,
    input  logic [ADDRESS_WIDTH-1:0]                    ic_addr,
    output logic                                        ic_done,
    input  logic                                        dc_req,
    input  logic                                        dc_we,
    input  logic [ADDRESS_WIDTH-1:0]                    dc_addr,
    input  logic [DATA_WIDTH-1:0]                       dc_wdata,
    output logic                                        dc_done,
    output logic [blk_width(DATA_WIDTH, BLOCK_SIZE)-1:0] rdata,
    output logic [ADDRESS_WIDTH-1:0]                    mem_address,
    output logic [DATA_WIDTH-1:0]                       mem_write_data,
    output logic                                        mem_write_enable,
    input  logic [blk_width(DATA_WIDTH, BLOCK_SIZE)-1:0] mem_read_data,
    output logic                                        busy
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    state_t                   state;
    state_t                   state_nx;
    owner_t                   owner;
    owner_t                   last_grant;
    logic [CW-1:0]            cnt;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic                     lat_we;
    logic                     grant_dc;

    always_comb begin
        state_nx = state;
        grant_dc = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the side that lost the previous grant wins
                grant_dc = dc_req && (!ic_req || (last_grant == OWN_IC));
                if (ic_req || dc_req) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IC;
            last_grant <= OWN_IC;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            rdata      <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        owner      <= grant_dc ? OWN_DC : OWN_IC;
                        last_grant <= grant_dc ? OWN_DC : OWN_IC;
                        lat_addr   <= grant_dc ? dc_addr : ic_addr;
                        lat_we     <= grant_dc && dc_we;
                        lat_wdata  <= grant_dc ? dc_wdata : '0;
                        cnt        <= CNT_INIT;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!lat_we) begin
                        rdata <= mem_read_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_address    = lat_addr;
    assign mem_write_data = lat_wdata;
    // Gated by rst so a reset landing on the commit cycle never writes
    assign mem_write_enable = (state == ACCESS) && (cnt == '0) && lat_we && !rst;
    assign ic_done = (state == RESP) && (owner == OWN_IC);
    assign dc_done = (state == RESP) && (owner == OWN_DC);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 30;
    localparam int BS = 1;
    localparam int ML = 2;
    localparam int BW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_done;
    logic          dc_req;
    logic          dc_we;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_wdata;
    logic          dc_done;
    logic [BW-1:0] rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_enable;
    logic [BW-1:0] mem_read_data;
    logic          busy;
    logic          mem_init;

    logic [DW-1:0] mem [0:63];

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .BLOCK_SIZE   (BS),
        .MEM_LATENCY  (ML)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ic_req          (ic_req),
        .ic_addr         (ic_addr),
        .ic_done         (ic_done),
        .dc_req          (dc_req),
        .dc_we           (dc_we),
        .dc_addr         (dc_addr),
        .dc_wdata        (dc_wdata),
        .dc_done         (dc_done),
        .rdata           (rdata),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_write_enable(mem_write_enable),
        .mem_read_data   (mem_read_data),
        .busy            (busy)
    );

    // Block-aligned datamemory model: word i initialised to A000_0000 + i
    assign mem_read_data = {mem[{mem_address[5:1], 1'b1}], mem[{mem_address[5:1], 1'b0}]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (mem_write_enable) begin
            mem[mem_address[5:0]] <= mem_write_data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst = 1'b1; mem_init = 1'b1;
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0;
        tick();
        tick();
        rst = 1'b0; mem_init = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_init = 1'b1;
        ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b1;
        ic_addr = 30'h3; dc_addr = 30'h5; dc_wdata = 32'h1234_5678;
        tick();
        tick();
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total++; if (ic_done !== 1'b0 || dc_done !== 1'b0)
            $display("FAIL reset_done: got ic=%b dc=%b want 0/0", ic_done, dc_done); else pass_cnt++;
        total++; if (mem_write_enable !== 1'b0) $display("FAIL reset_we: got %b want 0", mem_write_enable); else pass_cnt++;
        total++; if (mem_address !== 30'h0) $display("FAIL reset_addr: got %h want 0", mem_address); else pass_cnt++;
        total++; if (mem_write_data !== 32'h0) $display("FAIL reset_wdata: got %h want 0", mem_write_data); else pass_cnt++;
        total++; if (rdata !== 64'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else pass_cnt++;
        rst = 1'b0; mem_init = 1'b0;
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL reset_idle: got busy=%b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_read;
        reset_dut();
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 30'h10;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c <= 2) begin
                total++; if (mem_address !== 30'h10)
                    $display("FAIL read_addr c%0d: got %h want 10", c, mem_address); else pass_cnt++;
            end
            total++; if (dc_done !== 1'(c == 3))
                $display("FAIL read_done c%0d: got %b want %b", c, dc_done, (c == 3)); else pass_cnt++;
            if (c == 3) begin
                total++; if (rdata !== 64'hA000_0011_A000_0010)
                    $display("FAIL read_rdata: got %h want A0000011A0000010", rdata); else pass_cnt++;
                dc_req = 1'b0;
            end
        end
    endtask

    task automatic test_write;
        int we_cnt = 0;
        int we_cyc = -1;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 30'h4; dc_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (mem_write_enable) begin
                we_cnt++;
                we_cyc = c;
            end
            if (c == 3) begin
                total++; if (dc_done !== 1'b1) $display("FAIL write_done: got %b want 1", dc_done); else pass_cnt++;
                total++; if (rdata !== 64'hA000_0011_A000_0010)
                    $display("FAIL write_rdata_hold: got %h want A0000011A0000010", rdata); else pass_cnt++;
                dc_req = 1'b0; dc_we = 1'b0;
            end
        end
        total++; if (we_cnt !== 1) $display("FAIL write_we_count: got %0d want 1", we_cnt); else pass_cnt++;
        total++; if (we_cyc !== 2) $display("FAIL write_we_cycle: got %0d want 2", we_cyc); else pass_cnt++;
        dc_req = 1'b1; dc_addr = 30'h4;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 3) begin
                total++; if (dc_done !== 1'b1) $display("FAIL readback_done: got %b want 1", dc_done); else pass_cnt++;
                total++; if (rdata !== 64'hA000_0005_DEAD_BEEF)
                    $display("FAIL readback_rdata: got %h want A0000005DEADBEEF", rdata); else pass_cnt++;
                dc_req = 1'b0;
            end
        end
    endtask

    task automatic test_tie;
        logic [16:0] dcv = '0;
        logic [16:0] icv = '0;
        reset_dut();
        ic_req = 1'b1; ic_addr = 30'h20;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 30'h10;
        for (int c = 1; c <= 16; c++) begin
            tick();
            dcv[c] = dc_done;
            icv[c] = ic_done;
            if (c == 7) begin
                total++; if (rdata !== 64'hA000_0021_A000_0020)
                    $display("FAIL tie_ic_rdata: got %h want A0000021A0000020", rdata); else pass_cnt++;
            end
            if (dc_done) dc_req = 1'b0;
            if (ic_done) ic_req = 1'b0;
            if (c == 8) begin
                ic_req = 1'b1;
                dc_req = 1'b1;
            end
        end
        ic_req = 1'b0; dc_req = 1'b0;
        total++; if (dcv !== 17'h00808) $display("FAIL tie_dc_cycles: got %h want 00808", dcv); else pass_cnt++;
        total++; if (icv !== 17'h08080) $display("FAIL tie_ic_cycles: got %h want 08080", icv); else pass_cnt++;
    endtask

    task automatic test_alternate;
        logic [7:0] seq = '0;
        int n = 0;
        int coinc = 0;
        reset_dut();
        ic_req = 1'b1; ic_addr = 30'h20;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 30'h10;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (ic_done && dc_done) coinc++;
            if ((ic_done || dc_done) && n < 8) begin
                seq[n] = dc_done;
                n++;
            end
        end
        ic_req = 1'b0; dc_req = 1'b0;
        total++; if (coinc !== 0) $display("FAIL alt_coincident: got %0d want 0", coinc); else pass_cnt++;
        total++; if (n !== 6) $display("FAIL alt_count: got %0d want 6", n); else pass_cnt++;
        total++; if (seq !== 8'b0001_0101) $display("FAIL alt_order: got %b want 00010101", seq); else pass_cnt++;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL alt_idle: got busy=%b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_write;
        int we_seen = 0;
        int done_seen = 0;
        reset_dut();
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 30'h8; dc_wdata = 32'h1234_5678;
        tick();
        tick();
        rst = 1'b1; dc_req = 1'b0; dc_we = 1'b0;
        #1;
        if (mem_write_enable) we_seen++;
        if (dc_done || ic_done) done_seen++;
        tick();
        rst = 1'b0;
        if (mem_write_enable) we_seen++;
        total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            if (dc_done || ic_done) done_seen++;
            tick();
            if (mem_write_enable) we_seen++;
        end
        total++; if (we_seen !== 0) $display("FAIL rstmid_we: got %0d want 0", we_seen); else pass_cnt++;
        total++; if (done_seen !== 0) $display("FAIL rstmid_done: got %0d want 0", done_seen); else pass_cnt++;
        total++; if (mem[8] !== 32'hA000_0008) $display("FAIL rstmid_mem: got %h want A0000008", mem[8]); else pass_cnt++;
    endtask

    task automatic test_ic_drop;
        reset_dut();
        ic_req = 1'b1; ic_addr = 30'h21;
        tick();
        ic_req = 1'b0;
        tick();
        total++; if (busy !== 1'b1) $display("FAIL drop_busy: got %b want 1", busy); else pass_cnt++;
        tick();
        total++; if (ic_done !== 1'b1 || dc_done !== 1'b0)
            $display("FAIL drop_done: got ic=%b dc=%b want 1/0", ic_done, dc_done); else pass_cnt++;
        total++; if (rdata !== 64'hA000_0021_A000_0020)
            $display("FAIL drop_rdata: got %h want A0000021A0000020", rdata); else pass_cnt++;
        tick();
        total++; if (busy !== 1'b0 || ic_done !== 1'b0)
            $display("FAIL drop_idle: got busy=%b ic=%b want 0/0", busy, ic_done); else pass_cnt++;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL drop_no_regrant: got %b want 0", busy); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0;
        test_reset();
        test_read();
        test_write();
        test_tie();
        test_alternate();
        test_reset_mid_write();
        test_ic_drop();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single backing data memory between the instruction-cache refill port and the data-cache port (refill reads and write-through writes). Sequences each access over a fixed multi-cycle memory latency and returns a one-cycle done pulse with the block read data. Sits between both caches and datamemory, driving its address/write_data/write_enable and capturing its block-wide read_data.

Parameters:
DATA_WIDTH, 32, bits per word
ADDRESS_WIDTH, 30, word-address width (byte address bits [1:0] already stripped)
BLOCK_SIZE, 1, log2 words per block; block bus width BW = DATA_WIDTH*2**BLOCK_SIZE
MEM_LATENCY, 2, cycles the address must be held before read data is valid or a write commits; must be >= 1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
ic_req  input  1  instruction-side request; held until ic_done
ic_addr  input  ADDRESS_WIDTH  instruction block word address
ic_done  output  1  one-cycle completion pulse for instruction side
dc_req  input  1  data-side request; held until dc_done
dc_we  input  1  1 = write, 0 = block read
dc_addr  input  ADDRESS_WIDTH  data word address
dc_wdata  input  DATA_WIDTH  write word
dc_done  output  1  one-cycle completion pulse for data side
rdata  output  BW  block read data; valid only while ic_done or dc_done
mem_address  output  ADDRESS_WIDTH  to datamemory address
mem_write_data  output  DATA_WIDTH  to datamemory write_data
mem_write_enable  output  1  to datamemory write_enable
mem_read_data  input  BW  from datamemory read_data
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at an edge): state IDLE, cnt 0, last_grant = IC, ic_done/dc_done 0, mem_write_enable 0, mem_address 0, mem_write_data 0, rdata 0. Reset mid-transaction aborts it: no write commits, no done pulse.
- States: IDLE, ACCESS, RESP.
- IDLE: if any req is high at the edge, latch owner, addr, we (0 for IC), wdata; cnt <= MEM_LATENCY-1; go to ACCESS. Otherwise stay.
- Arbitration when both requests are high: grant the side not granted last (round-robin). After reset last_grant = IC, so DC wins the first tie. A single request is granted immediately regardless of last_grant. last_grant updates on each grant.
- ACCESS: mem_address and mem_write_data are driven from the latched registers and are stable for the whole state. Decrement cnt each edge. mem_write_enable is high only in the ACCESS cycle where cnt == 0 and the latched we = 1, giving exactly one write edge. At the edge with cnt == 0, capture mem_read_data into rdata for reads and go to RESP.
- RESP: assert the owner's done for exactly one cycle. IC reads return the full block; DC reads return the full block, and the requester extracts the word. For writes, rdata holds its previous value. Next edge goes to IDLE.
- Timing: req first high in cycle 0 with the arbiter IDLE gives done high in cycle MEM_LATENCY+1. The next grant is sampled in cycle MEM_LATENCY+2, so sustained throughput is one access per MEM_LATENCY+2 cycles.
- A requester must drop req in the cycle after done. A req still high in IDLE is treated as a new request.
- A req dropped during ACCESS does not abort the transaction; done still pulses.
- Request inputs are ignored outside IDLE.
- ic_done and dc_done are never high in the same cycle.

Decomposition:
- Package mem_arb_pkg holds state_t enum {IDLE, ACCESS, RESP}, owner_t enum {OWN_IC, OWN_DC} and a function blk_width(DATA_WIDTH, BLOCK_SIZE).
- No sub-module. The latency counter and FSM fit in one always_ff plus one always_comb.

Test Plan:
- Reset then dc_req=1, dc_we=0, dc_addr=0x10, MEM_LATENCY=2 -> mem_address=0x10 in cycles 1-2; dc_done=1 only in cycle 3; rdata equals the memory block at 0x10.
- dc write dc_addr=0x4, dc_wdata=0xDEADBEEF -> mem_write_enable high exactly one cycle (cycle 2). A subsequent read of 0x4 returns 0xDEADBEEF in the addressed word.
- ic_req and dc_req both high from reset -> DC served first (dc_done cycle 3), then IC granted in cycle 4 (ic_done cycle 7). Next tie after that grants DC.
- Both held continuously for 6 transactions -> grants alternate DC, IC, DC, IC, DC, IC; ic_done and dc_done are never coincident.
- rst asserted in cycle 2 of a write -> mem_write_enable never rises, no done pulse, busy=0 in the cycle after reset.
- ic_req dropped during ACCESS -> ic_done still pulses in cycle MEM_LATENCY+1, then IDLE with no new grant.
